seven_seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that sits directly upstream of the 7-segment binary decoder. It holds a frame of NUM_DIGITS 4-bit digit codes and drives one code at a time onto the decoder's 4-bit input. In step with that it drives active-low digit-select (anode) lines with a guard interval between digits, so a single decoder serves a multi-digit common-anode display. New frames are loaded with a pulse and applied only at a frame boundary, so the display never shows a mix of old and new digits.

---
 rtl/seven_seg_scan_ctrl.sv | 119 +++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Feeds one digit code at a time to a shared decoder and drives active-low anodes with a guard gap.
module seven_seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic [NUM_DIGITS-1:0]     blank_in,
   output logic [3:0]                D,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      load_ack,
   output logic                      frame_tick
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DW = 4 * NUM_DIGITS;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]         cnt, cnt_n;
   logic [IW-1:0]         idx, idx_n;
   logic [DW-1:0]         shd_d, shd_d_n, pnd_d, pnd_d_n;
   logic [NUM_DIGITS-1:0] shd_b, shd_b_n, pnd_b, pnd_b_n;
   logic                  pnd_v, pnd_v_n;
   logic                  boundary;
   logic                  ack_n;
   logic                  drive;
   logic [3:0]            d_n;
   logic [NUM_DIGITS-1:0] an_n;

   // Next-state: slot/digit advance, pending capture, frame-boundary swap
   always_comb begin
      cnt_n    = cnt;
      idx_n    = idx;
      shd_d_n  = shd_d;
      shd_b_n  = shd_b;
      pnd_d_n  = pnd_d;
      pnd_b_n  = pnd_b;
      pnd_v_n  = pnd_v;
      boundary = 1'b0;
      ack_n    = 1'b0;

      if (load) begin
         pnd_d_n = digits_in;
         pnd_b_n = blank_in;
         pnd_v_n = 1'b1;
      end

      if (en) begin
         if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (idx == IDX_LAST) begin
               idx_n    = '0;
               boundary = 1'b1;
            end else begin
               idx_n = idx + IW'(1);
            end
         end else begin
            cnt_n = cnt + CW'(1);
         end
      end

      // A load on the boundary edge has already overwritten pending above
      if (boundary && pnd_v_n) begin
         shd_d_n = pnd_d_n;
         shd_b_n = pnd_b_n;
         pnd_v_n = 1'b0;
         ack_n   = 1'b1;
      end
   end

   // Output decode from the next-state so outputs stay aligned with cnt/idx
   always_comb begin
      d_n   = '0;
      an_n  = '1;
      drive = en && (32'(cnt_n) >= GUARD);
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_n == IW'(i)) begin
            d_n = shd_d_n[4*i +: 4];
            if (drive && !shd_b_n[i]) an_n[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         shd_d      <= '0;
         shd_b      <= '1;
         pnd_d      <= '0;
         pnd_b      <= '0;
         pnd_v      <= 1'b0;
         D          <= '0;
         an         <= '1;
         load_ack   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= cnt_n;
         idx        <= idx_n;
         shd_d      <= shd_d_n;
         shd_b      <= shd_b_n;
         pnd_d      <= pnd_d_n;
         pnd_b      <= pnd_b_n;
         pnd_v      <= pnd_v_n;
         D          <= d_n;
         an         <= an_n;
         load_ack   <= ack_n;
         frame_tick <= boundary;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position model checked every cycle, plus directed literal checks.
module tb_seven_seg_scan_ctrl;

   localparam int N = 4;
   localparam int R = 8;
   localparam int G = 2;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  blank_in;
   logic [3:0]  D;
   logic [3:0]  an;
   logic        load_ack;
   logic        frame_tick;

   int n_chk  = 0;
   int n_fail = 0;
   int ack_cnt = 0;
   bit chk_on = 0;

   seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD(G)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load),
      .digits_in(digits_in), .blank_in(blank_in),
      .D(D), .an(an), .load_ack(load_ack), .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: position within the frame in cycles; display derived from pos / R and pos % R
   int          pos;
   logic [15:0] sd, pd;
   logic [3:0]  sb, pb;
   bit          pv;
   logic [3:0]  exp_an, exp_d;
   logic        exp_tick, exp_ack;

   task automatic model_step();
      if (!rst_n) begin
         pos = 0; sd = '0; sb = 4'hF; pd = '0; pb = '0; pv = 0;
         exp_an = 4'hF; exp_d = '0; exp_tick = 1'b0; exp_ack = 1'b0;
      end else begin
         exp_tick = 1'b0;
         exp_ack  = 1'b0;
         if (load) begin
            pd = digits_in; pb = blank_in; pv = 1;
         end
         if (en) begin
            pos = (pos + 1) % (N * R);
            if (pos == 0) begin
               exp_tick = 1'b1;
               if (pv) begin
                  sd = pd; sb = pb; pv = 0; exp_ack = 1'b1;
               end
            end
         end
         exp_d = 4'((sd >> (4 * (pos / R))) & 16'hF);
         if (!en || (pos % R) < G || ((sb >> (pos / R)) & 4'h1) != 4'h0)
            exp_an = 4'hF;
         else
            exp_an = ~(4'h1 << (pos / R));
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         check("an", 32'(an), 32'(exp_an));
         check("D", 32'(D), 32'(exp_d));
         check("frame_tick", 32'(frame_tick), 32'(exp_tick));
         check("load_ack", 32'(load_ack), 32'(exp_ack));
      end
   end

   initial forever begin
      @(negedge clk);
      if (load_ack === 1'b1) ack_cnt++;
   end

   task automatic wait_tick(output int n);
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) begin
            n = i;
            break;
         end
      end
      check("tick_seen", 32'(n != 0), 32'd1);
   endtask

   // Starting on a frame_tick cycle: D at each slot start, an at offset GUARD
   task automatic capture(output logic [15:0] dv, output logic [15:0] av);
      dv = '0;
      av = '0;
      for (int p = 0; p < N * R; p++) begin
         if (p % R == 0) dv = dv | (16'(D) << (4 * (p / R)));
         if (p % R == G) av = av | (16'(an) << (4 * (p / R)));
         @(negedge clk);
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] b);
      digits_in = d;
      blank_in  = b;
      load      = 1'b1;
      @(negedge clk);
      load      = 1'b0;
   endtask

   initial begin
      int n;
      int a0;
      logic [15:0] dv, av;
      rst_n = 1'b0; en = 1'b1; load = 1'b0; digits_in = '0; blank_in = '0;
      @(posedge clk);
      chk_on = 1;
      @(negedge clk);
      rst_n = 1'b1;

      // Idle: first frame_tick 32 cycles after reset, display dark
      wait_tick(n);
      check("first_tick_period", 32'(n), 32'd32);
      check("idle_an", 32'(an), 32'hF);
      check("idle_D", 32'(D), 32'h0);
      repeat (8) @(negedge clk);

      // Single load, applied at next boundary
      do_load(16'h7531, 4'h0);
      wait_tick(n);
      check("ack_latency", 32'(n + 1), 32'd24);
      check("ack_7531", 32'(load_ack), 32'd1);
      capture(dv, av);
      check("frame_d_7531", 32'(dv), 32'h7531);
      check("frame_an_7531", 32'(av), 32'h7BDE);

      // Two loads in one frame: last wins, one ack
      a0 = ack_cnt;
      do_load(16'h1111, 4'h0);
      repeat (3) @(negedge clk);
      do_load(16'h2222, 4'h0);
      wait_tick(n);
      check("ack_2222", 32'(load_ack), 32'd1);
      capture(dv, av);
      check("frame_d_2222", 32'(dv), 32'h2222);
      check("frame_an_2222", 32'(av), 32'h7BDE);
      check("ack_count_double", 32'(ack_cnt - a0), 32'd1);

      // Load on the boundary edge overrides pending
      a0 = ack_cnt;
      do_load(16'h3333, 4'h0);
      repeat (30) @(negedge clk);
      do_load(16'h4444, 4'h0);
      check("bnd_tick", 32'(frame_tick), 32'd1);
      check("bnd_ack", 32'(load_ack), 32'd1);
      capture(dv, av);
      check("frame_d_4444", 32'(dv), 32'h4444);
      check("frame_an_4444", 32'(av), 32'h7BDE);
      check("no_stale_ack", 32'(load_ack), 32'd0);
      check("ack_count_bnd", 32'(ack_cnt - a0), 32'd1);

      // Enable gap of 10 cycles mid-slot of digit 2
      repeat (18) @(negedge clk);
      check("pre_gap_an", 32'(an), 32'hB);
      en = 1'b0;
      @(negedge clk);
      check("gap_an", 32'(an), 32'hF);
      check("gap_D", 32'(D), 32'h4);
      repeat (9) @(negedge clk);
      en = 1'b1;
      wait_tick(n);
      check("stretched_period", 32'(28 + n), 32'd42);

      // Leading-zero blanking
      do_load(16'h0012, 4'b1100);
      blank_in = 4'h0;
      wait_tick(n);
      check("ack_blank", 32'(load_ack), 32'd1);
      capture(dv, av);
      check("frame_d_blank", 32'(dv), 32'h0012);
      check("frame_an_blank", 32'(av), 32'hFFDE);

      // Asynchronous reset mid drive phase drops pending data
      do_load(16'h9999, 4'h0);
      repeat (9) @(negedge clk);
      check("pre_rst_an", 32'(an), 32'hD);
      #2 rst_n = 1'b0;
      #1;
      check("rst_an", 32'(an), 32'hF);
      check("rst_D", 32'(D), 32'h0);
      check("rst_ack", 32'(load_ack), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      a0 = ack_cnt;
      repeat (40) @(negedge clk);
      check("post_rst_no_ack", 32'(ack_cnt - a0), 32'd0);
      check("post_rst_an", 32'(an), 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
